// File: rtl/cpu_control_sequencer_if.sv
// Control bundle between the microcode sequencer and the datapath.
interface cpu_control_sequencer_if #(
    parameter int unsigned op_bits = 4
) ();
    logic               run;
    logic [op_bits-1:0] opcode;
    logic               pc_out;
    logic               pc_inc;
    logic               pc_load;
    logic               mar_load;
    logic               ram_out;
    logic               ir_load;
    logic               ir_out;
    logic               a_load;
    logic               a_out;
    logic               b_load;
    logic               alu_out;
    logic               alu_sub;
    logic               out_load;
    logic               halted;
    logic [2:0]         tstate;

    // Sequencer side: consumes run/opcode, drives every enable.
    modport master (
        input  run, opcode,
        output pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load, ir_out,
               a_load, a_out, b_load, alu_out, alu_sub, out_load, halted, tstate
    );

    // Datapath side: supplies run/opcode, obeys the enables.
    modport slave (
        output run, opcode,
        input  pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load, ir_out,
               a_load, a_out, b_load, alu_out, alu_sub, out_load, halted, tstate
    );
endinterface

// File: rtl/cpu_control_sequencer.sv
// Microcode sequencer: fixed 6 T-state cycle (3 fetch, 3 execute) with
// opcode-decoded register/bus enables for the 8-bit accumulator CPU.
module cpu_control_sequencer #(
    parameter int unsigned bits    = 8,
    parameter int unsigned op_bits = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    cpu_control_sequencer_if.master bus
);

    // The opcode field must fit inside the instruction word.
    if (op_bits == 0 || op_bits > bits) begin : g_width_check
        $error("cpu_control_sequencer: op_bits must be in 1..bits");
    end

    localparam logic [op_bits-1:0] op_lda = op_bits'(4'h1);
    localparam logic [op_bits-1:0] op_add = op_bits'(4'h2);
    localparam logic [op_bits-1:0] op_sub = op_bits'(4'h3);
    localparam logic [op_bits-1:0] op_jmp = op_bits'(4'h6);
    localparam logic [op_bits-1:0] op_out = op_bits'(4'hE);
    localparam logic [op_bits-1:0] op_hlt = op_bits'(4'hF);

    // Encoding is visible on tstate, so values are fixed.
    typedef enum logic [2:0] {
        st_idle = 3'd0,
        st_t1   = 3'd1,
        st_t2   = 3'd2,
        st_t3   = 3'd3,
        st_t4   = 3'd4,
        st_t5   = 3'd5,
        st_t6   = 3'd6,
        st_halt = 3'd7
    } state_t;

    state_t state;
    state_t state_next;

    // State register; reset abandons any partial instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= st_idle;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and enable decode from the registered T-state plus opcode.
    always_comb begin
        state_next   = state;
        bus.pc_out   = 1'b0;
        bus.pc_inc   = 1'b0;
        bus.pc_load  = 1'b0;
        bus.mar_load = 1'b0;
        bus.ram_out  = 1'b0;
        bus.ir_load  = 1'b0;
        bus.ir_out   = 1'b0;
        bus.a_load   = 1'b0;
        bus.a_out    = 1'b0;
        bus.b_load   = 1'b0;
        bus.alu_out  = 1'b0;
        bus.alu_sub  = 1'b0;
        bus.out_load = 1'b0;
        bus.halted   = 1'b0;
        bus.tstate   = 3'(state);

        unique case (state)
            st_idle: begin
                if (bus.run) begin
                    state_next = st_t1;
                end
            end
            st_t1: begin
                bus.pc_out   = 1'b1;
                bus.mar_load = 1'b1;
                state_next   = st_t2;
            end
            st_t2: begin
                bus.pc_inc = 1'b1;
                state_next = st_t3;
            end
            st_t3: begin
                bus.ram_out = 1'b1;
                bus.ir_load = 1'b1;
                state_next  = st_t4;
            end
            st_t4: begin
                if (bus.opcode == op_lda || bus.opcode == op_add || bus.opcode == op_sub) begin
                    bus.ir_out   = 1'b1;
                    bus.mar_load = 1'b1;
                end else if (bus.opcode == op_jmp) begin
                    bus.ir_out  = 1'b1;
                    bus.pc_load = 1'b1;
                end else if (bus.opcode == op_out) begin
                    bus.a_out    = 1'b1;
                    bus.out_load = 1'b1;
                end
                state_next = (bus.opcode == op_hlt) ? st_halt : st_t5;
            end
            st_t5: begin
                if (bus.opcode == op_lda) begin
                    bus.ram_out = 1'b1;
                    bus.a_load  = 1'b1;
                end else if (bus.opcode == op_add || bus.opcode == op_sub) begin
                    bus.ram_out = 1'b1;
                    bus.b_load  = 1'b1;
                    bus.alu_sub = (bus.opcode == op_sub);
                end
                state_next = st_t6;
            end
            st_t6: begin
                if (bus.opcode == op_add || bus.opcode == op_sub) begin
                    bus.alu_out = 1'b1;
                    bus.a_load  = 1'b1;
                    bus.alu_sub = (bus.opcode == op_sub);
                end
                state_next = bus.run ? st_t1 : st_idle;
            end
            st_halt: begin
                bus.halted = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Self-checking bench for cpu_control_sequencer against a table-driven
// micro-program model.
module tb_cpu_control_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    cpu_control_sequencer_if #(.op_bits(4)) bus ();

    cpu_control_sequencer #(.bits(8), .op_bits(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Enable vector, MSB first: pc_out pc_inc pc_load mar_load ram_out ir_load
    // ir_out a_load a_out b_load alu_out alu_sub out_load
    localparam logic [12:0] m_pc_out   = 13'h1000;
    localparam logic [12:0] m_pc_inc   = 13'h0800;
    localparam logic [12:0] m_pc_load  = 13'h0400;
    localparam logic [12:0] m_mar_load = 13'h0200;
    localparam logic [12:0] m_ram_out  = 13'h0100;
    localparam logic [12:0] m_ir_load  = 13'h0080;
    localparam logic [12:0] m_ir_out   = 13'h0040;
    localparam logic [12:0] m_a_load   = 13'h0020;
    localparam logic [12:0] m_a_out    = 13'h0010;
    localparam logic [12:0] m_b_load   = 13'h0008;
    localparam logic [12:0] m_alu_out  = 13'h0004;
    localparam logic [12:0] m_alu_sub  = 13'h0002;
    localparam logic [12:0] m_out_load = 13'h0001;

    wire [12:0] dut_mask = {bus.pc_out, bus.pc_inc, bus.pc_load, bus.mar_load,
                            bus.ram_out, bus.ir_load, bus.ir_out, bus.a_load,
                            bus.a_out, bus.b_load, bus.alu_out, bus.alu_sub,
                            bus.out_load};
    wire [4:0]  bus_drivers = {bus.pc_out, bus.ram_out, bus.ir_out, bus.a_out, bus.alu_out};

    // Micro-program model: fetch steps are shared, execute steps per opcode.
    logic [12:0] fetch_tab [3];
    logic [12:0] exec_tab  [16][3];

    task automatic init_model();
        for (int o = 0; o < 16; o++) begin
            for (int s = 0; s < 3; s++) exec_tab[o][s] = '0;
        end
        fetch_tab[0] = m_pc_out | m_mar_load;
        fetch_tab[1] = m_pc_inc;
        fetch_tab[2] = m_ram_out | m_ir_load;
        exec_tab[1][0]  = m_ir_out | m_mar_load;
        exec_tab[1][1]  = m_ram_out | m_a_load;
        exec_tab[2][0]  = m_ir_out | m_mar_load;
        exec_tab[2][1]  = m_ram_out | m_b_load;
        exec_tab[2][2]  = m_alu_out | m_a_load;
        exec_tab[3][0]  = m_ir_out | m_mar_load;
        exec_tab[3][1]  = m_ram_out | m_b_load | m_alu_sub;
        exec_tab[3][2]  = m_alu_out | m_a_load | m_alu_sub;
        exec_tab[6][0]  = m_ir_out | m_pc_load;
        exec_tab[14][0] = m_a_out | m_out_load;
    endtask

    function automatic logic [12:0] expect_mask(int t, logic [3:0] op);
        if (t >= 1 && t <= 3) return fetch_tab[t-1];
        if (t >= 4 && t <= 6) return exec_tab[op][t-4];
        return '0;
    endfunction

    // One instruction from T1 up to last_t; run is dropped at drop_at and set
    // to next_run during T6 so the following edge picks T1 or IDLE.
    task automatic run_instr(input logic [3:0] op, input bit next_run,
                             input int drop_at, input int last_t);
        bus.opcode = op;
        for (int t = 1; t <= last_t; t++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.tstate !== 3'(t)) begin
                errors++;
                $display("FAIL tstate op=%h: got %0d want %0d", op, bus.tstate, t);
            end
            checks++;
            if (dut_mask !== expect_mask(t, op)) begin
                errors++;
                $display("FAIL enables op=%h T%0d: got %b want %b", op, t, dut_mask, expect_mask(t, op));
            end
            checks++;
            if (bus.halted !== 1'b0) begin
                errors++;
                $display("FAIL halted op=%h T%0d: got %b want 0", op, t, bus.halted);
            end
            checks++;
            if ($countones(bus_drivers) > 1) begin
                errors++;
                $display("FAIL bus_excl op=%h T%0d: got drivers %b want at most one", op, t, bus_drivers);
            end
            if (t == drop_at) bus.run = 1'b0;
            if (t == 6) bus.run = next_run;
        end
    endtask

    // Sit in IDLE for n cycles, checking quiet outputs.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.tstate !== 3'd0 || dut_mask !== 13'd0 || bus.halted !== 1'b0) begin
                errors++;
                $display("FAIL idle: got tstate=%0d en=%b halted=%b want 0/0/0", bus.tstate, dut_mask, bus.halted);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.run = 1'b0;
        bus.opcode = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.tstate !== 3'd0 || dut_mask !== 13'd0 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got tstate=%0d en=%b halted=%b want 0/0/0", bus.tstate, dut_mask, bus.halted);
        end
        reset = 1'b1;
        idle_cycles(5);
    endtask

    task automatic test_lda();
        bus.run = 1'b1;
        run_instr(4'h1, 1'b1, 0, 6);
        run_instr(4'h1, 1'b0, 0, 6);
        idle_cycles(2);
    endtask

    task automatic test_add_sub();
        bus.run = 1'b1;
        run_instr(4'h2, 1'b1, 0, 6);
        run_instr(4'h3, 1'b0, 0, 6);
        idle_cycles(1);
    endtask

    task automatic test_jmp_out_nop();
        bus.run = 1'b1;
        run_instr(4'h6, 1'b1, 0, 6);
        run_instr(4'hE, 1'b1, 0, 6);
        run_instr(4'h9, 1'b1, 0, 6);
        run_instr(4'h0, 1'b0, 0, 6);
        idle_cycles(1);
    endtask

    task automatic test_run_drop();
        bus.run = 1'b1;
        run_instr(4'h2, 1'b0, 2, 6);
        idle_cycles(3);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [3:0] op;
            bit nr;
            op = 4'($urandom_range(0, 14));
            nr = ($urandom_range(0, 4) != 0);
            bus.run = 1'b1;
            run_instr(op, nr, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0, 6);
            if (!nr) idle_cycles(int'($urandom_range(1, 3)));
        end
        bus.run = 1'b0;
        idle_cycles(1);
    endtask

    task automatic test_async_reset();
        bus.run = 1'b1;
        run_instr(4'h3, 1'b1, 0, 5);
        #3 reset = 1'b0;
        #1;
        checks++;
        if (bus.tstate !== 3'd0 || dut_mask !== 13'd0 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got tstate=%0d en=%b halted=%b want 0/0/0", bus.tstate, dut_mask, bus.halted);
        end
        bus.run = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_halt();
        bus.run = 1'b1;
        run_instr(4'hF, 1'b1, 0, 4);
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.tstate !== 3'd7 || bus.halted !== 1'b1 || dut_mask !== 13'd0) begin
                errors++;
                $display("FAIL halt_hold cyc%0d: got tstate=%0d halted=%b en=%b want 7/1/0", i, bus.tstate, bus.halted, dut_mask);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.tstate !== 3'd0 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_exit: got tstate=%0d halted=%b want 0/0", bus.tstate, bus.halted);
        end
        bus.run = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        idle_cycles(2);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        init_model();
        test_reset();
        test_lda();
        test_add_sub();
        test_jmp_out_nop();
        test_run_drop();
        test_random();
        test_async_reset();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
